// File: rtl/ps2_key_transmitter_if.sv
// Request/status and PS/2 line bundle for the keystroke transmitter.
interface ps2_key_transmitter_if;
  logic [4:0] letter_in;
  logic       send;
  logic       ready;
  logic       invalid;
  logic       ps2_clk_out;
  logic       ps2_dat_out;

  modport master (
    output letter_in, send,
    input  ready, invalid, ps2_clk_out, ps2_dat_out
  );

  modport slave (
    input  letter_in, send,
    output ready, invalid, ps2_clk_out, ps2_dat_out
  );
endinterface

// File: rtl/ps2_key_transmitter.sv
// PS/2 device-side keystroke emulator: sends the set-2 make code for a
// letter A..Z, optionally followed by F0 and the make code again.
module ps2_key_transmitter #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 50000,
  parameter int SEND_BREAK = 1
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  ps2_key_transmitter_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_BIT  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // Set-2 make code for letter index 0..25; out-of-range maps to 0.
  function automatic logic [7:0] scan_code(input logic [4:0] letter);
    case (letter)
      5'd0:  scan_code = 8'h1C;  5'd1:  scan_code = 8'h32;
      5'd2:  scan_code = 8'h21;  5'd3:  scan_code = 8'h23;
      5'd4:  scan_code = 8'h24;  5'd5:  scan_code = 8'h2B;
      5'd6:  scan_code = 8'h34;  5'd7:  scan_code = 8'h33;
      5'd8:  scan_code = 8'h43;  5'd9:  scan_code = 8'h3B;
      5'd10: scan_code = 8'h42;  5'd11: scan_code = 8'h4B;
      5'd12: scan_code = 8'h3A;  5'd13: scan_code = 8'h31;
      5'd14: scan_code = 8'h44;  5'd15: scan_code = 8'h4D;
      5'd16: scan_code = 8'h15;  5'd17: scan_code = 8'h2D;
      5'd18: scan_code = 8'h1B;  5'd19: scan_code = 8'h2C;
      5'd20: scan_code = 8'h3C;  5'd21: scan_code = 8'h2A;
      5'd22: scan_code = 8'h1D;  5'd23: scan_code = 8'h22;
      5'd24: scan_code = 8'h35;  5'd25: scan_code = 8'h1A;
      default: scan_code = 8'h00;
    endcase
  endfunction

  // 11-bit frame, bit 0 sent first: start, data LSB-first, odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] data);
    make_frame = {1'b1, ~^data, data, 1'b0};
  endfunction

  logic [1:0]       state;
  logic [1:0]       byte_idx;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic             phase;
  logic [GAP_W-1:0] gap_cnt;
  logic             invalid_q;
  logic [7:0]       code_q;
  logic [10:0]      shreg;

  logic accept;
  logic letter_ok;
  logic slot_end;
  logic more_bytes;

  assign accept     = (state == S_IDLE) && bus.send;
  assign letter_ok  = (bus.letter_in <= 5'd25);
  assign slot_end   = (state == S_BIT) && (half_cnt == CNT_LAST) && phase;
  assign more_bytes = (SEND_BREAK != 0) && (byte_idx < 2'd2);

  assign bus.ready       = (state == S_IDLE);
  assign bus.invalid     = invalid_q;
  assign bus.ps2_clk_out = ~((state == S_BIT) && phase);
  assign bus.ps2_dat_out = (state == S_BIT) ? shreg[0] : 1'b1;

  // Control FSM: request accept, bit-slot timing, inter-byte gap.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      byte_idx  <= 2'd0;
      bit_cnt   <= 4'd0;
      half_cnt  <= '0;
      phase     <= 1'b0;
      gap_cnt   <= '0;
      invalid_q <= 1'b0;
    end else begin
      invalid_q <= accept && !letter_ok;
      case (state)
        S_IDLE: begin
          byte_idx <= 2'd0;
          if (accept && letter_ok) state <= S_LOAD;
        end
        S_LOAD: begin
          bit_cnt  <= 4'd0;
          half_cnt <= '0;
          phase    <= 1'b0;
          state    <= S_BIT;
        end
        S_BIT: begin
          if (half_cnt == CNT_LAST) begin
            half_cnt <= '0;
            phase    <= ~phase;
            if (phase) begin
              if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (more_bytes) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= S_LOAD;
            end else begin
              byte_idx <= 2'd0;
              state    <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Datapath: latch the make code on accept, load and shift the frame.
  always_ff @(posedge CLOCK_50) begin
    if (accept && letter_ok) code_q <= scan_code(bus.letter_in);
    if (state == S_LOAD)
      shreg <= make_frame((byte_idx == 2'd1) ? BREAK_PREFIX : code_q);
    else if (slot_end && (bit_cnt != 4'd10))
      shreg <= {1'b1, shreg[10:1]};
  end

endmodule

// File: tb/tb_ps2_key_transmitter.sv
// Directed bench for ps2_key_transmitter: two instances (with and without
// the break sequence) and a frame decoder on each PS/2 line pair.
module tb_ps2_key_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ps2_key_transmitter_if ifa ();
  ps2_key_transmitter_if ifb ();

  ps2_key_transmitter #(.CLK_DIV(4), .GAP_CYCLES(16), .SEND_BREAK(1)) dut_a (
    .CLOCK_50(clk), .reset(rst), .bus(ifa));
  ps2_key_transmitter #(.CLK_DIV(4), .GAP_CYCLES(16), .SEND_BREAK(0)) dut_b (
    .CLOCK_50(clk), .reset(rst), .bus(ifb));

  // Frame decoders: sample data on each PS/2 clock falling edge.
  logic [10:0] sh_a, sh_b;
  int          nb_a, nb_b;
  logic [10:0] fqa[$];
  logic [10:0] fqb[$];

  always @(negedge ifa.ps2_clk_out or posedge rst) begin
    if (rst) nb_a = 0;
    else begin
      sh_a = {ifa.ps2_dat_out, sh_a[10:1]};
      nb_a++;
      if (nb_a == 11) begin fqa.push_back(sh_a); nb_a = 0; end
    end
  end

  always @(negedge ifb.ps2_clk_out or posedge rst) begin
    if (rst) nb_b = 0;
    else begin
      sh_b = {ifb.ps2_dat_out, sh_b[10:1]};
      nb_b++;
      if (nb_b == 11) begin fqb.push_back(sh_b); nb_b = 0; end
    end
  end

  typedef struct {
    logic [4:0] letter;
    logic [7:0] code;
  } vec_t;
  vec_t vt[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [4:0] l);
    ifa.letter_in = l; ifa.send = 1'b1;
    tick();
    ifa.send = 1'b0;
    ifa.letter_in = 5'd31;
  endtask

  task automatic send_b(input logic [4:0] l);
    ifb.letter_in = l; ifb.send = 1'b1;
    tick();
    ifb.send = 1'b0;
    ifb.letter_in = 5'd31;
  endtask

  task automatic wait_idle_a(output int n);
    n = 0;
    while (ifa.ready == 1'b0 && n < 5000) begin tick(); n++; end
  endtask

  task automatic wait_idle_b(output int n);
    n = 0;
    while (ifb.ready == 1'b0 && n < 5000) begin tick(); n++; end
  endtask

  task automatic check_three_a(input string tag, input logic [10:0] e0,
                               input logic [10:0] e1, input logic [10:0] e2);
    check({tag, "_nframes"}, fqa.size(), 3);
    if (fqa.size() == 3) begin
      check({tag, "_frame0"}, fqa[0], e0);
      check({tag, "_frame1"}, fqa[1], e1);
      check({tag, "_frame2"}, fqa[2], e2);
    end
    fqa.delete();
  endtask

  initial begin
    int n;
    logic hi_err;
    logic [10:0] f;

    vt[0]  = '{5'd0,  8'h1C}; vt[1]  = '{5'd1,  8'h32}; vt[2]  = '{5'd2,  8'h21};
    vt[3]  = '{5'd3,  8'h23}; vt[4]  = '{5'd4,  8'h24}; vt[5]  = '{5'd5,  8'h2B};
    vt[6]  = '{5'd6,  8'h34}; vt[7]  = '{5'd7,  8'h33}; vt[8]  = '{5'd8,  8'h43};
    vt[9]  = '{5'd9,  8'h3B}; vt[10] = '{5'd10, 8'h42}; vt[11] = '{5'd11, 8'h4B};
    vt[12] = '{5'd12, 8'h3A}; vt[13] = '{5'd13, 8'h31}; vt[14] = '{5'd14, 8'h44};
    vt[15] = '{5'd15, 8'h4D}; vt[16] = '{5'd16, 8'h15}; vt[17] = '{5'd17, 8'h2D};
    vt[18] = '{5'd18, 8'h1B}; vt[19] = '{5'd19, 8'h2C}; vt[20] = '{5'd20, 8'h3C};
    vt[21] = '{5'd21, 8'h2A}; vt[22] = '{5'd22, 8'h1D}; vt[23] = '{5'd23, 8'h22};
    vt[24] = '{5'd24, 8'h35}; vt[25] = '{5'd25, 8'h1A};

    ifa.letter_in = 5'd0; ifa.send = 1'b0;
    ifb.letter_in = 5'd0; ifb.send = 1'b0;

    // Reset and idle
    repeat (3) tick();
    rst = 1'b0;
    hi_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifa.ready !== 1'b1 || ifa.invalid !== 1'b0 ||
          ifa.ps2_clk_out !== 1'b1 || ifa.ps2_dat_out !== 1'b1) hi_err = 1'b1;
    end
    check("idle_ready", ifa.ready, 1);
    check("idle_invalid", ifa.invalid, 0);
    check("idle_lines", {ifa.ps2_clk_out, ifa.ps2_dat_out}, 2'b11);
    check("idle_100_cycles_stable", hi_err, 0);

    // Letter A with break: 1C, F0, 1C
    fqa.delete();
    send_a(5'd0);
    check("a_ready_drop", ifa.ready, 0);
    wait_idle_a(n);
    check("a_busy_cycles", n, 315);
    check_three_a("a", 11'h438, 11'h7E0, 11'h438);

    // Letter Z, make only
    fqb.delete();
    send_b(5'd25);
    wait_idle_b(n);
    check("z_busy_cycles", n, 105);
    check("z_nframes", fqb.size(), 1);
    if (fqb.size() == 1) check("z_frame", fqb[0], 11'h434);
    fqb.delete();

    // Out-of-range letter
    send_a(5'd26);
    check("inv_pulse", ifa.invalid, 1);
    check("inv_ready", ifa.ready, 1);
    check("inv_lines", {ifa.ps2_clk_out, ifa.ps2_dat_out}, 2'b11);
    tick();
    check("inv_pulse_end", ifa.invalid, 0);
    repeat (20) tick();
    check("inv_ready_after", ifa.ready, 1);
    check("inv_no_frames", fqa.size(), 0);

    // Reset during bit 4 of the first frame
    send_a(5'd0);
    repeat (36) tick();
    check("rst_mid_busy", ifa.ready, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_lines", {ifa.ps2_clk_out, ifa.ps2_dat_out}, 2'b11);
    check("rst_mid_ready", ifa.ready, 1);
    #3 rst = 1'b0;
    tick();
    check("rst_no_partial", fqa.size(), 0);
    fqa.delete();
    send_a(5'd4);
    wait_idle_a(n);
    check("e_busy_cycles", n, 315);
    check_three_a("e", 11'h648, 11'h7E0, 11'h648);

    // All 26 letters through the decoder
    for (int i = 0; i < 26; i++) begin
      send_a(vt[i].letter);
      wait_idle_a(n);
      check($sformatf("l%0d_nframes", i), fqa.size(), 3);
      if (fqa.size() == 3) begin
        f = fqa[0];
        check($sformatf("l%0d_make", i), f[8:1], vt[i].code);
        check($sformatf("l%0d_startstop", i), {f[10], f[0]}, 2'b10);
        check($sformatf("l%0d_parity_odd", i), $countones(f[9:1]) % 2, 1);
        f = fqa[1];
        check($sformatf("l%0d_break", i), f[8:1], 8'hF0);
        f = fqa[2];
        check($sformatf("l%0d_make2", i), f[8:1], vt[i].code);
      end
      fqa.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
